// File: rtl/fir_serial_mac.sv
// Serial single-MAC FIR: one tap per enabled cycle, double-buffered coefficients
// that swap only at a frame boundary, rounded and saturated output.
module fir_serial_mac #(
  parameter int unsigned TAPS      = 64,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned ADDR_W    = $clog2(TAPS),
  parameter int unsigned ACC_W     = DATA_W + COEF_W + ADDR_W,
  parameter int unsigned OUT_SHIFT = COEF_W - 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic signed [DATA_W-1:0] i_signal_sample,
  input  logic                     i_write_enable,
  input  logic [ADDR_W-1:0]        i_write_address,
  input  logic signed [COEF_W-1:0] i_coeffs_in,
  input  logic                     i_write_done,
  output logic signed [DATA_W-1:0] o_sample,
  output logic                     o_valid,
  output logic                     o_swap_pending,
  output logic                     o_bank
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] RND = (ACC_W'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [ADDR_W-1:0]        count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] delay_q [TAPS];
  logic signed [DATA_W-1:0] delay_d [TAPS];
  logic signed [COEF_W-1:0] coef_q [2][TAPS];
  logic signed [COEF_W-1:0] coef_d [2][TAPS];
  logic                     bank_q, bank_d;
  logic                     pending_q, pending_d;
  logic                     wd_q, wd_d;
  logic                     wd_prev_q, wd_prev_d;
  logic signed [DATA_W-1:0] sample_q, sample_d;
  logic                     valid_q, valid_d;

  logic                     frame_end;
  logic                     wd_rise;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] sat_val;

  // MAC datapath and output rounding/saturation
  always_comb begin
    frame_end = clk_enable && (count_q == LAST);
    wd_rise   = wd_q && !wd_prev_q;
    prod      = delay_q[count_q] * coef_q[bank_q][count_q];
    acc_base  = acc_q;
    if (count_q == '0) begin
      acc_base = '0;
    end
    sum     = acc_base + ACC_W'(prod);
    rnd     = sum + RND;
    shifted = rnd >>> OUT_SHIFT;
    sat_val = DATA_W'(shifted);
    if (shifted > SAT_MAX) begin
      sat_val = DATA_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      sat_val = DATA_W'(SAT_MIN);
    end
  end

  // Next-state: phase counter, delay line, swap handshake, shadow-bank writes
  always_comb begin
    count_d   = count_q;
    acc_d     = acc_q;
    delay_d   = delay_q;
    coef_d    = coef_q;
    bank_d    = bank_q;
    pending_d = pending_q;
    wd_d      = i_write_done;
    wd_prev_d = wd_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;

    if (clk_enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + ADDR_W'(1);
      acc_d   = sum;
    end

    if (frame_end) begin
      delay_d[0] = i_signal_sample;
      for (int unsigned i = 1; i < TAPS; i++) begin
        delay_d[i] = delay_q[i-1];
      end
      sample_d = sat_val;
      valid_d  = 1'b1;
    end

    // An edge seen while already pending, or on the applying edge, is absorbed
    if (frame_end && pending_q) begin
      bank_d    = ~bank_q;
      pending_d = 1'b0;
    end else if (wd_rise) begin
      pending_d = 1'b1;
    end

    if (i_write_enable && !pending_q) begin
      coef_d[~bank_q][i_write_address] = i_coeffs_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      acc_q     <= '0;
      delay_q   <= '{default: '0};
      coef_q    <= '{default: '{default: '0}};
      bank_q    <= 1'b0;
      pending_q <= 1'b0;
      wd_q      <= 1'b0;
      wd_prev_q <= 1'b0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      acc_q     <= acc_d;
      delay_q   <= delay_d;
      coef_q    <= coef_d;
      bank_q    <= bank_d;
      pending_q <= pending_d;
      wd_q      <= wd_d;
      wd_prev_q <= wd_prev_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
    end
  end

  assign o_sample       = sample_q;
  assign o_valid        = valid_q;
  assign o_swap_pending = pending_q;
  assign o_bank         = bank_q;

endmodule
